// File: rtl/rounding_divider_pipe.sv
// Two-stage unsigned divide by 2^shift with selectable rounding and output saturation.
// Define RDIV_SAT_COUNT_EN to add the 16-bit saturation event counter (sat_count).
module rounding_divider_pipe #(
    parameter int OUT_WIDTH = 32,
    parameter int MAX_SHIFT = 8,
    parameter int SHIFT_W   = 4,
    localparam int IN_WIDTH = OUT_WIDTH + MAX_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic [1:0]           mode,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [OUT_WIDTH-1:0] dout,
`ifdef RDIV_SAT_COUNT_EN
    output logic [15:0]          sat_count,
`endif
    output logic                 sat
);
    localparam int STAGES = 2;

    logic [STAGES:1]      vld_pipe;
    logic                 advance2;
    logic [IN_WIDTH-1:0]  s1_q;
    logic                 s1_inc;

    logic [SHIFT_W-1:0]   sh, shm1;
    logic [IN_WIDTH-1:0]  q_c, r_c, half_c;
    logic                 inc_c;
    logic [IN_WIDTH:0]    sum_c;
    logic                 sat_c;
    logic [OUT_WIDTH-1:0] dout_c;

    assign advance2   = !vld_pipe[2] || dout_ready;
    assign din_ready  = !vld_pipe[1] || advance2;
    assign dout_valid = vld_pipe[2];

    // Stage 1: quotient and round-increment decision.
    always_comb begin
        sh     = (shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift;
        shm1   = sh - SHIFT_W'(1);
        q_c    = din >> sh;
        r_c    = din & ~({IN_WIDTH{1'b1}} << sh);
        half_c = IN_WIDTH'(1) << shm1;
        inc_c  = 1'b0;
        case (mode)
            2'd0:    inc_c = (r_c >= half_c);
            2'd1:    inc_c = 1'b0;
            2'd2:    inc_c = (r_c > half_c) || ((r_c == half_c) && q_c[0]);
            default: inc_c = (r_c != '0);
        endcase
        // shm1 wraps at sh==0, so half is meaningless there; no remainder exists anyway.
        if (sh == '0) inc_c = 1'b0;
    end

    // Stage 2: increment at full width, then clamp to the output range.
    always_comb begin
        sum_c  = {1'b0, s1_q} + (IN_WIDTH+1)'(s1_inc);
        sat_c  = |sum_c[IN_WIDTH:OUT_WIDTH];
        dout_c = sat_c ? {OUT_WIDTH{1'b1}} : sum_c[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s1_inc   <= 1'b0;
            dout     <= '0;
            sat      <= 1'b0;
        end else begin
            if (advance2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    dout <= dout_c;
                    sat  <= sat_c;
                end
            end
            if (din_ready) begin
                vld_pipe[1] <= din_valid;
                if (din_valid) begin
                    s1_q   <= q_c;
                    s1_inc <= inc_c;
                end
            end
        end
    end

`ifdef RDIV_SAT_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_count <= '0;
        else if (dout_valid && dout_ready && sat && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: doc/rounding_divider_pipe.md
ROUNDING_DIVIDER_PIPE -- requirements
Module: rounding_divider_pipe

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32: result width.
REQ-002 SHALL have parameter MAX_SHIFT, default 8: largest supported divide exponent, at least 1.
REQ-003 SHALL have parameter SHIFT_W, default 4: shift field width, large enough to encode MAX_SHIFT.
REQ-004 SHALL derive IN_WIDTH = OUT_WIDTH + MAX_SHIFT; it is not user-overridable.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port din_valid, input, 1: input beat present.
REQ-008 SHALL have port din_ready, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port din, input, IN_WIDTH: unsigned dividend.
REQ-010 SHALL have port shift, input, SHIFT_W: divide exponent, divisor is 2^shift.
REQ-011 SHALL have port mode, input, 2: rounding mode.
REQ-012 SHALL have port dout_valid, output, 1: result beat present.
REQ-013 SHALL have port dout_ready, input, 1: downstream accepts the result.
REQ-014 SHALL have port dout, output, OUT_WIDTH: rounded, saturated quotient.
REQ-015 SHALL have port sat, output, 1: the current dout was saturated.

Function
REQ-016 SHALL treat a shift value above MAX_SHIFT as MAX_SHIFT.
REQ-017 SHALL compute q = din >> shift and r = din mod 2^shift; half = 2^(shift-1).
REQ-018 SHALL apply mode 0, round-half-up: inc = (r >= half).
REQ-019 SHALL apply mode 1, truncate: inc = 0.
REQ-020 SHALL apply mode 2, round-half-even: inc = (r > half) or (r == half and q[0]).
REQ-021 SHALL apply mode 3, ceiling: inc = (r != 0).
REQ-022 SHALL force inc = 0 in every mode when shift is 0.
REQ-023 SHALL compute sum = q + inc at IN_WIDTH+1 bits, with no intermediate truncation.
REQ-024 SHALL, when sum > 2^OUT_WIDTH-1, output all ones with sat=1; otherwise output sum[OUT_WIDTH-1:0] with sat=0.
REQ-025 SHALL be a two-stage registered pipeline: stage 1 registers q and inc; stage 2 registers dout and sat.
REQ-026 SHALL accept a beat on a cycle with din_valid and din_ready both high.
REQ-027 SHALL assert dout_valid, with no stall, exactly 2 cycles after the accepting edge.
REQ-028 SHALL sustain throughput of one beat per cycle while dout_ready is held high.
REQ-029 SHALL define advance2 = !s2_valid || dout_ready.
REQ-030 SHALL drive din_ready = !s1_valid || advance2; a combinational path from dout_ready is permitted.
REQ-031 SHALL hold dout, sat and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-032 SHALL, under simultaneous output accept and input accept, move the stage-1 beat to stage 2 and load the new beat into stage 1 on the same edge, with no bubble and no loss.
REQ-033 SHALL preserve result order, with no duplication and no drop.
REQ-034 SHALL sample mode and shift only on the accepting cycle.

Reset
REQ-035 SHALL, on reset assertion, immediately clear all stage valids, dout, sat and the optional counter to 0, regardless of any clock edge.
REQ-036 SHALL discard any in-flight beats on reset mid-operation.
REQ-037 SHALL hold din_ready=1 while reset is asserted.
REQ-038 SHALL not produce dout_valid before the first beat accepted after reset release.

Configuration
REQ-039 SHALL, with RDIV_SAT_COUNT_EN defined, add output sat_count, 16 bits, clear on reset.
REQ-040 SHALL, with RDIV_SAT_COUNT_EN defined, increment sat_count once per output handshake with sat=1, saturating at 0xFFFF.
REQ-041 SHALL, without RDIV_SAT_COUNT_EN, have no sat_count port and no counter logic.

Verification (OUT_WIDTH=8, MAX_SHIFT=4, IN_WIDTH=12)
REQ-042 SHALL cover modes: din=20, shift=3, modes 0/1/2/3 -> dout 3/2/2/3, sat=0; din=12, shift=3, mode 2 -> 2.
REQ-043 SHALL cover saturation: din=0xFFF, shift=4, mode 0 -> dout=0xFF, sat=1; mode 1 -> 0xFF, sat=0.
REQ-044 SHALL cover shift edges: din=0x0AB, shift=0 -> dout=0xAB, sat=0; shift=9 clamped to 4 with din=0x158, mode 0 -> 0x16.
REQ-045 SHALL cover backpressure: stream 5 beats with dout_ready low for cycles 2-4 -> din_ready low after two beats buffered; all 5 results emerge in order with stable dout while stalled.
REQ-046 SHALL cover reset mid-stream: assert reset with both stages valid -> dout_valid=0 and dout=0 immediately; the first beat after release appears 2 cycles after its accept.
REQ-047 SHALL cover the counter under RDIV_SAT_COUNT_EN: 3 saturating beats -> sat_count=3; a saturating beat held under stall is counted once.
